// File: rtl/seq_barrel_shift_unit_if.sv
// rtl/seq_barrel_shift_unit_if.sv - start/operand/result bundle for the sequential barrel shifter
interface seq_barrel_shift_unit_if;
    logic        ctrl_shift;
    logic        ctrl_op;
    logic [31:0] data_operand;
    logic [4:0]  ctrl_shiftamt;
    logic [31:0] data_result;
    logic        data_busy;
    logic        data_resultRDY;

    modport master (
        output ctrl_shift,
        output ctrl_op,
        output data_operand,
        output ctrl_shiftamt,
        input  data_result,
        input  data_busy,
        input  data_resultRDY
    );

    modport slave (
        input  ctrl_shift,
        input  ctrl_op,
        input  data_operand,
        input  ctrl_shiftamt,
        output data_result,
        output data_busy,
        output data_resultRDY
    );
endinterface

// File: rtl/seq_barrel_shift_unit.sv
// rtl/seq_barrel_shift_unit.sv - multi-cycle 16/8/4/2/1 barrel shifter (SLL/SRA); optional SHIFT_EARLY_EXIT_EN
module seq_barrel_shift_unit #(
    parameter int WIDTH   = 32,
    parameter int NSTAGES = 5
) (
    input  logic                   clock,
    input  logic                   reset,
    seq_barrel_shift_unit_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   work;
    logic [WIDTH-1:0]   result;
    logic [WIDTH-1:0]   work_shifted;
    logic [4:0]         shamt;
    logic [4:0]         stage_amt;
    logic [2:0]         stage;
    logic               op;
    logic               start_accept;
    logic               last_stage;

    // A start is taken in IDLE or DONE; requests during SHIFT are dropped.
    assign start_accept = bus.ctrl_shift && (state != SHIFT);

    // Size of the current stage: 2^stage.
    always_comb begin
        stage_amt = 5'd1 << stage;
    end

    // One power-of-two stage applied to the working register.
    always_comb begin
        work_shifted = work;
        if (shamt[stage]) begin
            if (op) begin
                work_shifted = $unsigned($signed(work) >>> stage_amt);
            end else begin
                work_shifted = work << stage_amt;
            end
        end
    end

    // Decide whether this SHIFT edge is the final one.
    always_comb begin
`ifdef SHIFT_EARLY_EXIT_EN
        // Remaining lower stages would all pass through, so finish now.
        last_stage = (shamt & ((5'd1 << stage) - 5'd1)) == 5'd0;
`else
        last_stage = (stage == 3'd0);
`endif
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_accept) state_next = SHIFT;
            SHIFT:   if (last_stage)   state_next = DONE;
            DONE:    state_next = start_accept ? SHIFT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand latch, stage walk and result capture.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            work   <= '0;
            result <= '0;
            shamt  <= '0;
            op     <= 1'b0;
            stage  <= '0;
        end else if (start_accept) begin
            work  <= bus.data_operand;
            shamt <= bus.ctrl_shiftamt;
            op    <= bus.ctrl_op;
            stage <= 3'(NSTAGES - 1);
        end else if (state == SHIFT) begin
            work  <= work_shifted;
            stage <= stage - 3'd1;
            if (last_stage) begin
                result <= work_shifted;
            end
        end
    end

    assign bus.data_result    = result;
    assign bus.data_busy      = (state == SHIFT);
    assign bus.data_resultRDY = (state == DONE);

endmodule

// File: tb/tb_seq_barrel_shift_unit.sv
// tb/tb_seq_barrel_shift_unit.sv - directed and random checks of seq_barrel_shift_unit against a reference shift model
module tb_seq_barrel_shift_unit;

    logic clock;
    logic reset;
    int   n_tests;
    int   n_fail;
    logic [31:0] prev_result;

    seq_barrel_shift_unit_if bus_if ();

    seq_barrel_shift_unit dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ref_shift(input logic op, input logic [31:0] x, input int sh);
        if (op) return $unsigned($signed(x) >>> sh);
        return x << sh;
    endfunction

    function automatic int ref_latency(input int sh);
`ifdef SHIFT_EARLY_EXIT_EN
        int tz;
        tz = 0;
        while (tz < 5 && sh[tz] == 1'b0) tz++;
        return (5 - tz) < 1 ? 1 : 5 - tz;
`else
        return 5;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive a start for one edge, then scramble the inputs.
    task automatic start_op(input logic op, input logic [31:0] x, input logic [4:0] sh);
        @(negedge clock);
        bus_if.ctrl_shift    = 1'b1;
        bus_if.ctrl_op       = op;
        bus_if.data_operand  = x;
        bus_if.ctrl_shiftamt = sh;
        @(posedge clock);
        #1;
        bus_if.ctrl_shift    = 1'b0;
        bus_if.ctrl_op       = 1'($urandom);
        bus_if.data_operand  = $urandom;
        bus_if.ctrl_shiftamt = 5'($urandom);
        chk("busy_after_start", 32'(bus_if.data_busy), 32'd1);
    endtask

    // Wait for the ready pulse; returns at #1 inside the ready cycle.
    task automatic wait_ready(input string tag, input int exp_lat, input logic [31:0] exp_res);
        int lat;
        int busy_cnt;
        lat = 99;
        busy_cnt = 1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clock);
            #1;
            bus_if.ctrl_shift = 1'b0;
            if (bus_if.data_resultRDY) begin
                lat = c;
                break;
            end
            if (bus_if.data_busy) busy_cnt++;
            chk({tag, "_held"}, bus_if.data_result, prev_result);
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_lat));
        chk({tag, "_busy_at_ready"}, 32'(bus_if.data_busy), 32'd0);
        chk({tag, "_result"}, bus_if.data_result, exp_res);
        prev_result = exp_res;
    endtask

    task automatic pulse_end(input string tag);
        @(posedge clock);
        #1;
        chk({tag, "_rdy_single"}, 32'(bus_if.data_resultRDY), 32'd0);
        chk({tag, "_result_stable"}, bus_if.data_result, prev_result);
    endtask

    task automatic full_op(input string tag, input logic op, input logic [31:0] x, input logic [4:0] sh);
        start_op(op, x, sh);
        wait_ready(tag, ref_latency(int'(sh)), ref_shift(op, x, int'(sh)));
        pulse_end(tag);
    endtask

    initial begin
        int pulses;
        logic        rop;
        logic [31:0] rx;
        logic [4:0]  rsh;
        n_tests = 0;
        n_fail = 0;
        prev_result = 32'd0;
        reset = 1'b0;
        bus_if.ctrl_shift    = 1'b0;
        bus_if.ctrl_op       = 1'b0;
        bus_if.data_operand  = 32'd0;
        bus_if.ctrl_shiftamt = 5'd0;
        repeat (2) @(posedge clock);
        #1;
        chk("reset_result", bus_if.data_result, 32'd0);
        chk("reset_busy", 32'(bus_if.data_busy), 32'd0);
        chk("reset_rdy", 32'(bus_if.data_resultRDY), 32'd0);
        @(negedge clock);
        reset = 1'b1;

        full_op("sll_ffff_16", 1'b0, 32'h0000FFFF, 5'd16);
        chk("sll_ffff_16_const", prev_result, 32'hFFFF0000);
        full_op("sra_8000_31", 1'b1, 32'h80000000, 5'd31);
        chk("sra_8000_31_const", prev_result, 32'hFFFFFFFF);
        full_op("sra_7fff_4", 1'b1, 32'h7FFFFFFF, 5'd4);
        chk("sra_7fff_4_const", prev_result, 32'h07FFFFFF);
        full_op("sll_shamt0", 1'b0, 32'h12345678, 5'd0);
        full_op("sll_one_31", 1'b0, 32'h00000001, 5'd31);
        chk("sll_one_31_const", prev_result, 32'h80000000);
        full_op("sll_even_31", 1'b0, 32'hFFFFFFFE, 5'd31);
        full_op("sra_pos_31", 1'b1, 32'h12345678, 5'd31);
        full_op("sll_3_16", 1'b0, 32'h00000003, 5'd16);
        full_op("sll_3_1", 1'b0, 32'h00000003, 5'd1);
        chk("sll_3_1_const", prev_result, 32'h00000006);

        for (int i = 0; i < 20; i++) begin
            rop = 1'($urandom);
            rx  = $urandom;
            rsh = 5'($urandom_range(0, 31));
            full_op("random", rop, rx, rsh);
        end

        // Start during SHIFT is ignored.
        start_op(1'b0, 32'h0000000F, 5'd4);
        @(negedge clock);
        bus_if.ctrl_shift    = 1'b1;
        bus_if.ctrl_op       = 1'b1;
        bus_if.data_operand  = 32'hDEADBEEF;
        bus_if.ctrl_shiftamt = 5'd3;
        wait_ready("ignore_in_shift", ref_latency(4), 32'h000000F0);
        // Start in the DONE cycle is accepted while the old pulse is visible.
        chk("done_restart_old_rdy", 32'(bus_if.data_resultRDY), 32'd1);
        start_op(1'b1, 32'hF0000000, 5'd2);
        wait_ready("done_restart", ref_latency(2), 32'hFC000000);
        pulse_end("done_restart");

        // Reset in the second SHIFT cycle aborts the operation.
        start_op(1'b0, 32'h0000FFFF, 5'd16);
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        chk("midreset_result", bus_if.data_result, 32'd0);
        chk("midreset_busy", 32'(bus_if.data_busy), 32'd0);
        chk("midreset_rdy", 32'(bus_if.data_resultRDY), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clock);
            #1;
            if (bus_if.data_resultRDY || bus_if.data_busy) pulses++;
        end
        chk("midreset_no_pulse", 32'(pulses), 32'd0);
        prev_result = 32'd0;
        full_op("after_reset", 1'b1, 32'h87654321, 5'd8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_barrel_shift_unit.md
Name: seq_barrel_shift_unit

Overview:
- Multi-cycle shift unit feeding the ALU's 16/8/4/2/1 fixed-shift stages.
- Latches a 32-bit operand, a 5-bit shift amount and an op select, then applies one power-of-two stage per clock, largest first (16 → 1).
- Sits between the ALU operand/control decode and the ALU result mux.
- Gives the multdiv/ALU control path a registered shift with a start/ready handshake instead of a single long combinational shift chain.

Parameters:
- WIDTH, 32, datapath width; only 32 is supported, and stage sizes are fixed at 16/8/4/2/1.
- NSTAGES, 5, number of shift stages, equal to the shamt width.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset; 0 clears all state immediately.
- ctrl_shift  in  1  start request; sampled on the rising clock edge.
- ctrl_op  in  1  0 = SLL (logical left, zero fill), 1 = SRA (arithmetic right, sign fill).
- data_operand  in  32  value to shift.
- ctrl_shiftamt  in  5  shift amount, 0..31.
- data_result  out  32  shifted value; held stable from ready until the next accepted start.
- data_busy  out  1  high while a shift is in progress.
- data_resultRDY  out  1  one-cycle pulse when data_result is valid.

Behaviour:
- Reset (reset=0, asynchronous) sets:
  - state = IDLE
  - data_result = 0, data_busy = 0, data_resultRDY = 0
  - internal operand, shamt, op and stage index = 0
- Reset asserted mid-operation aborts the shift; no ready pulse is produced.
- States: IDLE, SHIFT, DONE.
- IDLE, or DONE, with ctrl_shift=1 at an edge:
  - latch data_operand into the working register; latch ctrl_shiftamt and ctrl_op.
  - set stage index = 4; go to SHIFT.
- SHIFT: each edge handles stage k (size 2^k).
  - If shamt[k]=1: SLL shifts the working register left by 2^k and fills zeros in the low bits; SRA shifts it right by 2^k and fills with bit 31.
  - If shamt[k]=0: the register is unchanged.
  - Decrement k. After the k=0 edge, copy the working register to data_result and go to DONE.
- DONE: data_resultRDY=1 for exactly this cycle, then go to IDLE unless a new start is accepted.
- data_busy=1 exactly while in SHIFT.
- Latency: with start sampled at edge N, data_resultRDY is high in the cycle after edge N+5. This is fixed at 5 SHIFT cycles.
- ctrl_shift while in SHIFT is ignored; there is no queueing and latched operands are unaffected.
- ctrl_shift in DONE is accepted. The ready pulse for the old result still occurs in that cycle; the next cycle is SHIFT.
- data_operand, ctrl_op and ctrl_shiftamt may change freely after the start edge.
- shamt=0: all stages pass through; result = operand after the full latency.
- shamt=31: SLL gives 0 unless operand bit 0 is set (result 0x80000000 when it is). SRA gives all bit-31 copies (0 or 0xFFFFFFFF).
- data_result changes only on the DONE transition or on reset. It never shows intermediate stage values.

Optional Feature:
- Macro: SHIFT_EARLY_EXIT_EN.
- Defined:
  - On any SHIFT edge where shamt bits below the current stage are all zero, the result is written and the FSM goes to DONE after that edge.
  - Latency becomes max(1, 5 − trailing_zeros(shamt)) SHIFT cycles. shamt=0 and shamt=16 take 1 cycle; shamt=1 takes 5.
  - data_busy follows the shortened SHIFT occupancy.
- Undefined: fixed 5-cycle SHIFT occupancy for every shamt; no early-exit logic is synthesised.

Test Plan:
- Reset mid-shift: start SLL 0x0000FFFF shamt=16, assert reset at SHIFT cycle 2 → outputs 0 immediately, state IDLE, no ready pulse after release.
- SLL 0x0000FFFF shamt=16 → data_resultRDY pulses 5 cycles after the start edge; data_result=0xFFFF0000; data_busy high for exactly 5 cycles.
- SRA 0x80000000 shamt=31 → 0xFFFFFFFF. SRA 0x7FFFFFFF shamt=4 → 0x07FFFFFF.
- SLL 0x12345678 shamt=0 → 0x12345678 after 5 cycles. SLL 0x00000001 shamt=31 → 0x80000000.
- Back-to-back: second start during SHIFT is ignored (result matches the first op only); a start in the DONE cycle is accepted, the old ready pulse still fires, and the second result arrives 5 cycles later.
- With SHIFT_EARLY_EXIT_EN: SLL 0x00000003 shamt=16 → ready after 1 SHIFT cycle, result 0x00030000; shamt=1 → 5 cycles, result 0x00000006.
